// File: rtl/ysyx_22050612_ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ysyx_22050612_ifu_pkg;

  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
  localparam logic [31:0] NOP_INST         = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_WAIT  = 2'd2,
    S_FLUSH = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifu_entry_t;

endpackage

// File: rtl/ysyx_22050612_ifu_fifo.sv
// Instruction buffer: power-of-two depth FIFO of {pc, inst} entries with synchronous flush.
module ysyx_22050612_ifu_fifo
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  ifu_entry_t               push_data,
  output logic [$clog2(DEPTH):0]   count,
  output ifu_entry_t               head,
  output logic                     empty,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);

  ifu_entry_t    mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !flush && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ysyx_22050612_ifu.sv
// Instruction fetch unit: PC, single-outstanding fetch FSM, instruction buffer toward decode,
// and redirect handling with stale-response tracking.
module ysyx_22050612_ifu
  import ysyx_22050612_ifu_pkg::*;
#(
  parameter logic [63:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [63:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic [63:0] fetch_pc
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_e  state;
  logic [63:0] pc;
  logic [63:0] req_pc;
  logic [CW-1:0] fifo_count;
  ifu_entry_t  fifo_head;
  ifu_entry_t  push_entry;
  logic        fifo_empty;
  logic        fifo_full;
  logic        credit_ok;
  logic        fire;
  logic        push;
  logic        pop;

  // Requests leave only from REQ, where nothing is outstanding, so the credit is the free space.
  assign credit_ok      = fifo_count < CW'(FIFO_DEPTH);
  assign imem_req_valid = (state == S_REQ) && credit_ok;
  assign imem_req_addr  = pc;
  assign fire           = imem_req_valid && imem_req_ready;
  assign push           = (state == S_WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop            = inst_valid && inst_ready && !redirect_valid;
  assign push_entry     = '{pc: req_pc, inst: imem_rsp_data};

  assign inst_valid = !fifo_empty;
  assign inst       = inst_valid ? fifo_head.inst : NOP_INST;
  assign inst_pc    = inst_valid ? fifo_head.pc : '0;
  assign fetch_pc   = pc;

  ysyx_22050612_ifu_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .flush     (redirect_valid),
    .push_data (push_entry),
    .count     (fifo_count),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      pc     <= RESET_PC;
      req_pc <= '0;
    end else if (redirect_valid) begin
      pc <= redirect_pc & ~64'h3;
      // A response landing in the redirect cycle settles the one owed response, from WAIT too.
      unique case (state)
        S_WAIT:  state <= imem_rsp_valid ? S_REQ : S_FLUSH;
        S_REQ:   state <= fire ? S_FLUSH : S_REQ;
        S_FLUSH: state <= imem_rsp_valid ? S_REQ : S_FLUSH;
        default: state <= S_REQ;
      endcase
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (fire) begin
            req_pc <= pc;
            pc     <= pc + 64'd4;
            state  <= S_WAIT;
          end
        end
        S_WAIT:  if (imem_rsp_valid) state <= S_REQ;
        S_FLUSH: if (imem_rsp_valid) state <= S_REQ;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(imem_rsp_valid && !(state inside {S_WAIT, S_FLUSH})));
      assert (!(push && fifo_full && !pop));
    end
  end

endmodule
